// File: rtl/cdb_arbiter.sv
// Common data bus arbiter.
// Each functional unit owns a one-entry result slot. Occupied slots compete
// round-robin for a single registered broadcast on the CDB. A slot can be
// drained and refilled in the same cycle, so one FU can stream at full rate.
module cdb_arbiter #(
  parameter int   N_FU     = 4,
  parameter int   BITWIDTH = 32,
  parameter int   TAG_W    = 6,
  localparam int  SRC_W    = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [N_FU-1:0]          fu_valid,
  input  logic [N_FU*TAG_W-1:0]    fu_tag,
  input  logic [N_FU*BITWIDTH-1:0] fu_data,
  output logic [N_FU-1:0]          fu_ready,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [BITWIDTH-1:0]      cdb_data,
  output logic [SRC_W-1:0]         cdb_src
);

  logic [N_FU-1:0]     occ;
  logic [TAG_W-1:0]    slot_tag  [N_FU];
  logic [BITWIDTH-1:0] slot_data [N_FU];
  logic [SRC_W-1:0]    rr_ptr;

  logic                any_occ;
  logic [SRC_W-1:0]    win;
  logic [N_FU-1:0]     grant;
  logic [N_FU-1:0]     xfer;
  logic [SRC_W-1:0]    rr_next;

  // First occupied slot at or after ptr, wrapping past N_FU-1 back to 0.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [N_FU-1:0]  req,
                                               input logic [SRC_W-1:0] ptr);
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    logic [SRC_W-1:0] sel;
    logic             found;
    sel   = '0;
    found = 1'b0;
    for (int off = 0; off < N_FU; off++) begin
      sum = {1'b0, ptr} + (SRC_W+1)'(off);
      if (sum >= (SRC_W+1)'(N_FU)) sum = sum - (SRC_W+1)'(N_FU);
      idx = sum[SRC_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  // Grant depends only on occ and rr_ptr, keeping fu_valid off the ready path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    any_occ  = |occ;
    win      = rr_pick(occ, rr_ptr);
    grant    = '0;
    if (any_occ) grant = N_FU'(1) << win;
    rr_next  = (win == SRC_W'(N_FU - 1)) ? '0 : win + SRC_W'(1);
    fu_ready = {N_FU{rst & en & ~flush}} & (~occ | grant);
    xfer     = fu_valid & fu_ready;
  end

  // Slot capture/drain, round-robin pointer and the registered broadcast.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst) begin
      occ       <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      // NOTE: slot storage is reset too, so a broadcast can never expose stale pre-reset data.
      for (int i = 0; i < N_FU; i++) begin
        slot_tag[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else if (flush) begin
      occ       <= '0;
      cdb_valid <= 1'b0;
    end else if (en) begin
      cdb_valid <= any_occ;
      if (any_occ) begin
        cdb_tag  <= slot_tag[win];
        cdb_data <= slot_data[win];
        cdb_src  <= win;
        rr_ptr   <= rr_next;
      end
      for (int i = 0; i < N_FU; i++) begin
        if (xfer[i]) begin
          occ[i]       <= 1'b1;
          slot_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
          slot_data[i] <= fu_data[i*BITWIDTH +: BITWIDTH];
        end else if (grant[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

endmodule
